frac_cen_gen: RTL and testbench

//  Parametrised, run-time reprogrammable fractional clock-enable generator.

---
 rtl/frac_cen_pkg.sv | 12 +
 rtl/frac_cen_ch.sv | 50 +++++
 rtl/frac_cen_gen.sv | 53 +++++
 tb/tb_frac_cen_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/frac_cen_pkg.sv
// frac_cen_pkg: shared widths, ratio type and numerator clamp for the fractional enable generator.
package frac_cen_pkg;
  localparam int W_DEF = 10;
  localparam int LOCK_CYC_DEF = 16;
  typedef struct packed {
    logic [W_DEF-1:0] num;
    logic [W_DEF-1:0] den;
  } ratio_t;
  function automatic int unsigned clampnum(input int unsigned num, input int unsigned den);
    return num < den ? num : den;
  endfunction
endpackage

// File: rtl/frac_cen_ch.sv
// frac_cen_ch: one fractional clock-enable channel with a shadow ratio applied glitchlessly on wrap.
module frac_cen_ch import frac_cen_pkg::*; #(
  parameter int W = W_DEF,
  parameter int DEF_NUM = 24,
  parameter int DEF_DEN = 25
) (
  input  logic         refclk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_num,
  input  logic [W-1:0] ld_den,
  output logic         cen,
  output logic         pending,
  output logic         pending_nxt
);
  logic [W-1:0] acc, num, den, sh_num, sh_den;
  logic [W:0] s;
  logic off, wrap, apply;
  always_comb begin
    off = (den == '0) | (num == '0);
    s = {1'b0, acc} + (W+1)'(clampnum(32'(num), 32'(den)));
    wrap = ~off & (s >= {1'b0, den});
    apply = pending & (wrap | off);
    pending_nxt = ld | (pending & ~apply);
  end
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      num <= W'(DEF_NUM);
      den <= W'(DEF_DEN);
      sh_num <= '0;
      sh_den <= '0;
      pending <= 1'b0;
      cen <= 1'b0;
    end else begin
      cen <= wrap;
      // A new ratio restarts from a clean phase so the first period is exact.
      acc <= (apply | off) ? '0 : wrap ? W'(s - {1'b0, den}) : W'(s);
      if (apply) begin
        num <= sh_num;
        den <= sh_den;
      end
      if (ld) begin
        sh_num <= ld_num;
        sh_den <= ld_den;
      end
      pending <= pending_nxt;
    end
  end
endmodule

// File: rtl/frac_cen_gen.sv
// frac_cen_gen: NUM_CH run-time reprogrammable fractional clock enables with a lock indicator.
module frac_cen_gen import frac_cen_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int W = W_DEF,
  parameter int DEF_NUM = 24,
  parameter int DEF_DEN = 25,
  parameter int LOCK_CYC = LOCK_CYC_DEF,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int CNTW = LOCK_CYC > 0 ? $clog2(LOCK_CYC + 1) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [W-1:0]      cfg_num,
  input  logic [W-1:0]      cfg_den,
  output logic [NUM_CH-1:0] cen,
  output logic [NUM_CH-1:0] pending,
  output logic              locked
);
  logic [(1<<CW)-1:0] pend_pad;
  logic [NUM_CH-1:0] pend_nxt, ld;
  logic [CNTW-1:0] cnt;
  // Unused channel codes read as not pending, so they are accepted and dropped.
  always_comb begin
    pend_pad = '0;
    pend_pad[NUM_CH-1:0] = pending;
    cfg_ready = rst_n & ~pend_pad[cfg_ch];
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ld[i] = cfg_valid & cfg_ready & (cfg_ch == CW'(i));
    frac_cen_ch #(.W(W), .DEF_NUM(DEF_NUM), .DEF_DEN(DEF_DEN)) u_ch (
      .refclk(refclk),
      .rst_n(rst_n),
      .ld(ld[i]),
      .ld_num(cfg_num),
      .ld_den(cfg_den),
      .cen(cen[i]),
      .pending(pending[i]),
      .pending_nxt(pend_nxt[i])
    );
  end
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      locked <= 1'b0;
    end else begin
      cnt <= (cnt == CNTW'(LOCK_CYC)) ? cnt : cnt + 1'b1;
      locked <= (cnt == CNTW'(LOCK_CYC)) & ~|pend_nxt;
    end
  end
endmodule

// File: tb/tb_frac_cen_gen.sv
// tb_frac_cen_gen: directed scenarios with hand-computed enable patterns for frac_cen_gen.
module tb_frac_cen_gen;
  logic refclk = 1'b0;
  logic rst_n, cfg_valid, cfg_ready, locked;
  logic [1:0] cfg_ch;
  logic [9:0] cfg_num, cfg_den;
  logic [3:0] cen, pending;
  int n_chk = 0;
  int n_fail = 0;
  int edge_n = 0;

  frac_cen_gen dut (
    .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_num(cfg_num), .cfg_den(cfg_den),
    .cen(cen), .pending(pending), .locked(locked)
  );

  always #5 refclk = ~refclk;

  task automatic step();
    @(negedge refclk);
    edge_n++;
  endtask

  task automatic test_reset();
    int win[2][4];
    win = '{default: 0};
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0;
    repeat (2) @(negedge refclk);
    n_chk++; if (cen !== 4'h0) begin n_fail++; $display("FAIL reset_cen got %h exp 0", cen); end
    n_chk++; if (pending !== 4'h0) begin n_fail++; $display("FAIL reset_pending got %h exp 0", pending); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
    n_chk++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", cfg_ready); end
    rst_n = 1'b1;
    edge_n = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      for (int c = 0; c < 4; c++) if (cen[c]) win[(k-1)/25][c]++;
      if (k == 1) begin
        n_chk++; if (cen !== 4'h0) begin n_fail++; $display("FAIL first_edge_cen got %h exp 0", cen); end
      end
      if (k == 2) begin
        n_chk++; if (cen !== 4'hf) begin n_fail++; $display("FAIL second_edge_cen got %h exp f", cen); end
      end
      if (k == 16) begin
        n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got %b exp 0", locked); end
      end
      if (k == 17) begin
        n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_rise got %b exp 1", locked); end
      end
    end
    for (int w = 0; w < 2; w++)
      for (int c = 0; c < 4; c++) begin
        n_chk++;
        if (win[w][c] != 24) begin n_fail++; $display("FAIL window%0d_ch%0d pulses got %0d exp 24", w, c, win[w][c]); end
      end
  endtask

  task automatic test_retune();
    cfg_ch = 2'd1; cfg_num = 10'd1; cfg_den = 10'd4; cfg_valid = 1'b1;
    n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL retune_ready got %b exp 1", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    for (int k = 51; k <= 60; k++) begin
      if (k > 51) step();
      n_chk++;
      if (cen[1] !== (k == 52 || k == 56 || k == 60)) begin n_fail++; $display("FAIL retune_cen1 edge %0d got %b", k, cen[1]); end
      n_chk++;
      if (cen[0] !== (k % 25 != 1)) begin n_fail++; $display("FAIL retune_cen0 edge %0d got %b", k, cen[0]); end
      n_chk++;
      if (pending !== ((k == 51) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL retune_pending edge %0d got %h", k, pending); end
      n_chk++;
      if (locked !== (k != 51)) begin n_fail++; $display("FAIL retune_locked edge %0d got %b", k, locked); end
    end
  endtask

  task automatic test_disable();
    cfg_ch = 2'd2; cfg_num = 10'd5; cfg_den = 10'd0; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 61; k <= 66; k++) begin
      if (k > 61) step();
      n_chk++;
      if (cen[2] !== (k <= 62)) begin n_fail++; $display("FAIL disable_cen2 edge %0d got %b", k, cen[2]); end
      n_chk++;
      if (pending[2] !== (k == 61)) begin n_fail++; $display("FAIL disable_pending edge %0d got %b", k, pending[2]); end
    end
    cfg_num = 10'd3; cfg_den = 10'd3; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int k = 67; k <= 72; k++) begin
      if (k > 67) step();
      n_chk++;
      if (cen[2] !== (k >= 69)) begin n_fail++; $display("FAIL enable_cen2 edge %0d got %b", k, cen[2]); end
      n_chk++;
      if (pending[2] !== (k == 67)) begin n_fail++; $display("FAIL enable_pending edge %0d got %b", k, pending[2]); end
    end
  endtask

  task automatic test_over_unity();
    cfg_ch = 2'd3; cfg_num = 10'd30; cfg_den = 10'd7; cfg_valid = 1'b1;
    step();
    cfg_num = 10'd2; cfg_den = 10'd5;
    n_chk++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b exp 0", cfg_ready); end
    n_chk++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL over_pending got %b exp 1", pending[3]); end
    n_chk++; if (cen[3] !== 1'b1) begin n_fail++; $display("FAIL over_cen3 edge 73 got %b exp 1", cen[3]); end
    step();
    cfg_valid = 1'b0;
    for (int k = 74; k <= 80; k++) begin
      if (k > 74) step();
      n_chk++;
      if (cen[3] !== 1'b1) begin n_fail++; $display("FAIL over_cen3 edge %0d got %b exp 1", k, cen[3]); end
      n_chk++;
      if (pending[3] !== 1'b0) begin n_fail++; $display("FAIL busy_dropped edge %0d got %b exp 0", k, pending[3]); end
    end
  endtask

  task automatic test_back_to_back();
    repeat (3) step();
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL wrap_pre_locked got %b exp 1", locked); end
    cfg_ch = 2'd1; cfg_num = 10'd1; cfg_den = 10'd2; cfg_valid = 1'b1;
    n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready got %b exp 1", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    for (int k = 84; k <= 92; k++) begin
      if (k > 84) step();
      n_chk++;
      if (cen[1] !== (k == 84 || k == 88 || k == 90 || k == 92)) begin n_fail++; $display("FAIL wrap_cen1 edge %0d got %b", k, cen[1]); end
      n_chk++;
      if (pending[1] !== (k <= 87)) begin n_fail++; $display("FAIL wrap_pending edge %0d got %b", k, pending[1]); end
      n_chk++;
      if (locked !== (k >= 88)) begin n_fail++; $display("FAIL wrap_locked edge %0d got %b", k, locked); end
    end
  endtask

  task automatic test_reset_mid();
    cfg_ch = 2'd1; cfg_num = 10'd1; cfg_den = 10'd5; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_chk++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL mid_pre_pending got %h exp 2", pending); end
    n_chk++; if (cen[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_cen0 got %b exp 1", cen[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (cen !== 4'h0) begin n_fail++; $display("FAIL mid_async_cen got %h exp 0", cen); end
    n_chk++; if (pending !== 4'h0) begin n_fail++; $display("FAIL mid_async_pending got %h exp 0", pending); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_async_locked got %b exp 0", locked); end
    n_chk++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL mid_async_ready got %b exp 0", cfg_ready); end
    @(negedge refclk);
    rst_n = 1'b1;
    edge_n = 0;
    for (int k = 1; k <= 17; k++) begin
      step();
      n_chk++;
      if (cen !== ((k == 1) ? 4'h0 : 4'hf)) begin n_fail++; $display("FAIL mid_resume_cen edge %0d got %h", k, cen); end
      n_chk++;
      if (locked !== (k == 17)) begin n_fail++; $display("FAIL mid_resume_locked edge %0d got %b", k, locked); end
    end
    n_chk++; if (pending !== 4'h0) begin n_fail++; $display("FAIL mid_resume_pending got %h exp 0", pending); end
  endtask

  initial begin
    test_reset();
    test_retune();
    test_disable();
    test_over_unity();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
